// File: rtl/debug_bridge_pkg.sv
// Shared types for the debug bridge: the buffered entry, the halt FSM states and the halt offset.
// No logic here; latency and backpressure live in debug_bridge and dbg_fifo.
package debug_bridge_pkg;

    localparam logic [23:0] HALT_OFFSET_DEF = 24'h000004;

    typedef struct packed {
        logic [23:0] addr;
        logic [31:0] data;
        logic [63:0] tick;
    } dbg_entry_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

endpackage

// File: rtl/dbg_fifo.sv
// Synchronous FIFO of dbg_entry_t; a pushed entry is readable from the next cycle.
// The caller must not push when full or pop when empty; no full-FIFO bypass.
module dbg_fifo
    import debug_bridge_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  dbg_entry_t wdata_i,
    input  logic       pop_i,
    output dbg_entry_t rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    dbg_entry_t    mem_q [DEPTH];
    dbg_entry_t    mem_d [DEPTH];
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[head_q];

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_i) begin
            mem_d[tail_q] = wdata_i;
            tail_d        = tail_q + AW'(1);
        end
        if (pop_i) begin
            head_d = head_q + AW'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/debug_bridge.sv
// CPU-to-debug-sink bridge: timestamps window stores, queues them, replays in order; halt store is always last.
// Entry visible one cycle after accept; CPU stalls when full or draining/halted, sink paces pops via dbg_ready_i.
module debug_bridge
    import debug_bridge_pkg::*;
#(
    parameter int          DEPTH       = 8,
    parameter logic [7:0]  DBG_WINDOW  = 8'h80,
    parameter logic [23:0] HALT_OFFSET = HALT_OFFSET_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cpu_en_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    output logic        cpu_stall_o,
    output logic        dbg_en_o,
    output logic        dbg_we_o,
    output logic [23:0] dbg_addr_o,
    output logic [31:0] dbg_data_o,
    output logic [63:0] dbg_tick_o,
    input  logic        dbg_ready_i,
    output logic [63:0] tick_cntr_o
);

    logic [63:0] tick_q, tick_d;
    state_t      state_q, state_d;
    logic        hit, accept, pop, full, empty;
    dbg_entry_t  push_entry, head;

    assign hit         = cpu_en_i & cpu_we_i & (cpu_addr_i[31:24] == DBG_WINDOW);
    assign cpu_stall_o = hit & (full | (state_q != RUN));
    assign accept      = hit & ~cpu_stall_o;
    assign pop         = dbg_en_o & dbg_ready_i;

    assign push_entry = '{addr: cpu_addr_i[23:0], data: cpu_data_i, tick: tick_q};

    dbg_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (accept),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // Outputs are forced to zero while empty so stale RAM contents never leak to the sink.
    assign dbg_en_o    = ~empty;
    assign dbg_we_o    = dbg_en_o;
    assign dbg_addr_o  = dbg_en_o ? head.addr : '0;
    assign dbg_data_o  = dbg_en_o ? head.data : '0;
    assign dbg_tick_o  = dbg_en_o ? head.tick : '0;
    assign tick_cntr_o = tick_q;

    always_comb begin
        tick_d  = tick_q + 64'd1;
        state_d = state_q;
        case (state_q)
            RUN:     if (accept && (cpu_addr_i[23:0] == HALT_OFFSET)) state_d = DRAIN;
            // Nothing is accepted while draining, so the first halt-offset pop is the halt store itself.
            DRAIN:   if (pop && (head.addr == HALT_OFFSET)) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tick_q  <= '0;
            state_q <= RUN;
        end else begin
            tick_q  <= tick_d;
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_debug_bridge.sv
// Directed bench for debug_bridge: per-cycle vector table plus hand-written halt and reset sequences.
module tb_debug_bridge;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cpu_en_i, cpu_we_i, dbg_ready_i;
    logic [31:0] cpu_addr_i, cpu_data_i;
    logic        cpu_stall_o, dbg_en_o, dbg_we_o;
    logic [23:0] dbg_addr_o;
    logic [31:0] dbg_data_o;
    logic [63:0] dbg_tick_o, tick_cntr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    debug_bridge #(.DEPTH(8), .DBG_WINDOW(8'h80), .HALT_OFFSET(24'h000004)) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cpu_en_i    (cpu_en_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_stall_o (cpu_stall_o),
        .dbg_en_o    (dbg_en_o),
        .dbg_we_o    (dbg_we_o),
        .dbg_addr_o  (dbg_addr_o),
        .dbg_data_o  (dbg_data_o),
        .dbg_tick_o  (dbg_tick_o),
        .dbg_ready_i (dbg_ready_i),
        .tick_cntr_o (tick_cntr_o)
    );

    typedef struct {
        logic        en, we, rdy;
        logic [31:0] addr, data;
        logic        x_stall, x_en;
        logic [23:0] x_addr;
        logic [31:0] x_data;
        logic [63:0] x_tick;
    } vec_t;

    vec_t vecs [29];

    function automatic vec_t mk(input logic en, we, input logic [31:0] addr, data, input logic rdy,
                                input logic x_stall, x_en, input logic [23:0] x_addr,
                                input logic [31:0] x_data, input logic [63:0] x_tick);
        vec_t v;
        v.en = en; v.we = we; v.addr = addr; v.data = data; v.rdy = rdy;
        v.x_stall = x_stall; v.x_en = x_en; v.x_addr = x_addr; v.x_data = x_data; v.x_tick = x_tick;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic en, we, input logic [31:0] addr, data, input logic rdy);
        cpu_en_i = en; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = data; dbg_ready_i = rdy;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_head(input string tag, input logic en, input logic [23:0] a,
                              input logic [31:0] d, input logic [63:0] t);
        chk({tag, " dbg_en"}, dbg_en_o, en);
        chk({tag, " dbg_we"}, dbg_we_o, en);
        chk({tag, " dbg_addr"}, dbg_addr_o, a);
        chk({tag, " dbg_data"}, dbg_data_o, d);
        chk({tag, " dbg_tick"}, dbg_tick_o, t);
    endtask

    task automatic pulse_reset();
        rst_ni = 1'b0;
        drive(0, 0, 0, 0, 1);
        step();
        rst_ni = 1'b1;
    endtask

    logic [23:0] h_addr [4];
    logic [31:0] h_data [4];

    initial begin
        rst_ni = 1'b0;
        drive(0, 0, 0, 0, 1);
        step();
        step();
        rst_ni = 1'b1;
        #1;
        chk("reset tick", tick_cntr_o, 64'd0);
        chk("reset stall", cpu_stall_o, 1'b0);
        check_head("reset", 1'b0, 24'h0, 32'h0, 64'd0);

        for (int c = 0; c < 10; c++) begin
            step();
            chk("idle stall", cpu_stall_o, 1'b0);
        end
        #1;
        chk("idle tick10", tick_cntr_o, 64'd10);
        chk("idle dbg_en", dbg_en_o, 1'b0);

        pulse_reset();
        #1;
        chk("rst restart tick", tick_cntr_o, 64'd0);

        // Table index equals the expected tick counter of that cycle.
        for (int c = 0; c < 5; c++) vecs[c] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        vecs[5] = mk(1, 1, 32'h8000_0000, 32'h41, 1, 0, 0, 0, 0, 0);
        vecs[6] = mk(0, 0, 0, 0, 1, 0, 1, 24'h0, 32'h41, 64'd5);
        vecs[7] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 9; k++) begin
            if (k == 0)
                vecs[8] = mk(1, 1, 32'h8000_0100, 32'hA0, 0, 0, 0, 0, 0, 0);
            else
                vecs[8+k] = mk(1, 1, 32'h8000_0100 + 32'(4*k), 32'hA0 + 32'(k), 0,
                               (k == 8), 1, 24'h100, 32'hA0, 64'd8);
        end
        vecs[17] = mk(1, 1, 32'h8000_0120, 32'hA8, 1, 1, 1, 24'h100, 32'hA0, 64'd8);
        vecs[18] = mk(1, 1, 32'h8000_0120, 32'hA8, 1, 0, 1, 24'h104, 32'hA1, 64'd9);
        for (int j = 2; j < 8; j++)
            vecs[17+j] = mk(0, 0, 0, 0, 1, 0, 1, 24'h100 + 24'(4*j), 32'hA0 + 32'(j), 64'd8 + 64'(j));
        vecs[25] = mk(0, 0, 0, 0, 1, 0, 1, 24'h120, 32'hA8, 64'd18);
        vecs[26] = mk(1, 1, 32'h4000_0000, 32'h55, 1, 0, 0, 0, 0, 0);
        vecs[27] = mk(1, 0, 32'h8000_0010, 32'h66, 1, 0, 0, 0, 0, 0);
        vecs[28] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 29; i++) begin
            drive(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].rdy);
            #2;
            chk($sformatf("vec%0d tick_cntr", i), tick_cntr_o, 64'(i));
            chk($sformatf("vec%0d stall", i), cpu_stall_o, vecs[i].x_stall);
            check_head($sformatf("vec%0d", i), vecs[i].x_en, vecs[i].x_addr, vecs[i].x_data, vecs[i].x_tick);
            step();
        end

        // Halt sequence starts at tick 29 with an empty FIFO.
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 32'h8000_0010 + 32'(4*k), 32'hB0 + 32'(k), 0);
            #2;
            chk("halt pre stall", cpu_stall_o, 1'b0);
            h_addr[k] = 24'h10 + 24'(4*k);
            h_data[k] = 32'hB0 + 32'(k);
            step();
        end
        drive(1, 1, 32'h8000_0004, 32'hDEAD, 0);
        h_addr[3] = 24'h4;
        h_data[3] = 32'hDEAD;
        #2;
        chk("halt store stall", cpu_stall_o, 1'b0);
        step();
        drive(1, 1, 32'h8000_0020, 32'hEE, 0);
        #2;
        chk("drain extra stall", cpu_stall_o, 1'b1);
        check_head("drain held", 1'b1, 24'h10, 32'hB0, 64'd29);
        step();
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 32'h8000_0020, 32'hEE, 1);
            #2;
            chk("drain stall", cpu_stall_o, 1'b1);
            check_head($sformatf("drain pop%0d", k), 1'b1, h_addr[k], h_data[k], 64'd29 + 64'(k));
            step();
        end
        for (int k = 0; k < 20; k++) begin
            #2;
            chk("halted stall", cpu_stall_o, 1'b1);
            chk("halted dbg_en", dbg_en_o, 1'b0);
            step();
        end

        // Reset leaves HALTED; then reset again with four entries queued.
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 32'h8000_0200 + 32'(4*k), 32'hC0 + 32'(k), 0);
            #2;
            chk("requeue stall", cpu_stall_o, 1'b0);
            step();
        end
        drive(0, 0, 0, 0, 0);
        #2;
        check_head("queued head", 1'b1, 24'h200, 32'hC0, 64'd0);
        step();
        pulse_reset();
        drive(1, 1, 32'h8000_0300, 32'hD0, 1);
        #2;
        chk("post rst tick", tick_cntr_o, 64'd0);
        chk("post rst stall", cpu_stall_o, 1'b0);
        check_head("post rst", 1'b0, 24'h0, 32'h0, 64'd0);
        step();
        drive(0, 0, 0, 0, 1);
        #2;
        check_head("post rst new", 1'b1, 24'h300, 32'hD0, 64'd0);
        step();
        #2;
        chk("post rst empty", dbg_en_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_bridge.md
# debug_bridge

Per-PE bridge between the CPU data port and the debug sink. Decodes CPU stores into the debug address window, timestamps each one with a free-running 64-bit tick counter, buffers them in a FIFO and replays them in order to the debug sink under a ready handshake. Handles the simulation-halt store so that it is always the last entry delivered. Also owns the tick counter that the sink uses for its own logging.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2
- DBG_WINDOW, 8'h80, value of cpu_addr_i[31:24] that selects the debug window
- HALT_OFFSET, 24'h000004, window offset of the halt register

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_ni  in  1  reset; synchronous, active-low
- cpu_en_i  in  1  CPU access valid this cycle
- cpu_we_i  in  1  access is a store
- cpu_addr_i  in  32  byte address
- cpu_data_i  in  32  store data
- cpu_stall_o  out  1  combinational; the CPU must hold the access while high
- dbg_en_o  out  1  entry presented to the sink
- dbg_we_o  out  1  equal to dbg_en_o
- dbg_addr_o  out  24  window offset of the entry
- dbg_data_o  out  32  store data of the entry
- dbg_tick_o  out  64  tick value captured at acceptance
- dbg_ready_i  in  1  sink consumes the presented entry this cycle; tied high for a plain sink
- tick_cntr_o  out  64  free-running tick counter

## Operation
- Tick counter: 0 after reset; increments by 1 every cycle; wraps 2^64−1 → 0.
- hit = cpu_en_i & cpu_we_i & (cpu_addr_i[31:24] == DBG_WINDOW).
- Loads to the window and all non-window accesses are ignored. They never stall.
- cpu_stall_o = hit & (full | state != RUN).
- Accept = hit & ~cpu_stall_o. On accept, push {cpu_addr_i[23:0], cpu_data_i, tick_cntr_o} into the FIFO.
- Output: dbg_en_o = FIFO not empty. The dbg_* outputs reflect the head entry.
- Pop = dbg_en_o & dbg_ready_i. The head is held stable while dbg_ready_i is low.
- FSM states:
  - RUN: normal operation. An accepted store with offset == HALT_OFFSET moves to DRAIN.
  - DRAIN: all hits stall. Entries drain normally. When the popped entry has offset == HALT_OFFSET, move to HALTED.
  - HALTED: all hits stall permanently, FIFO is empty, dbg_en_o = 0. Exit only by reset.
- Full: a hit stalls even if a pop happens in the same cycle; there is no bypass of a full FIFO.
- Empty: a push and a pop never share an entry. A pushed entry is visible no earlier than the next cycle.
- Simultaneous push and pop when neither empty nor full: count is unchanged and order is preserved.

## Timing
- Reset values: cpu_stall_o = 0 (unless a hit is stalled by HALTED/DRAIN — not possible after reset), dbg_en_o = 0, dbg_we_o = 0, dbg_addr_o = 0, dbg_data_o = 0, dbg_tick_o = 0, tick_cntr_o = 0, state = RUN, FIFO empty.
- Latency: a store accepted in cycle N appears on dbg_* in cycle N+1 when the FIFO was empty and ready is high.
- Throughput: one entry per cycle at both ports.
- Captured tick: the tick_cntr_o value during the accept cycle.
- Reset asserted mid-operation: FIFO contents are discarded, the FSM returns to RUN and the tick counter returns to 0 on the next edge.

## Structure
- Package debug_bridge_pkg:
  - dbg_entry_t struct {addr[23:0], data[31:0], tick[63:0]}
  - state enum {RUN, DRAIN, HALTED}
  - the default HALT_OFFSET constant
- Sub-module dbg_fifo:
  - synchronous FIFO of dbg_entry_t, DEPTH entries
  - head/tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH
  - count of $clog2(DEPTH)+1 bits
  - full/empty flags derived from count

## Test plan
- Reset, then idle 10 cycles → tick_cntr_o = 10, dbg_en_o = 0, no stalls.
- Store 0x80000000 ← 0x41 at tick 5, ready high → in cycle 6: dbg_en_o = 1, addr = 0, data = 0x41, tick = 5.
- ready low; 9 consecutive stores with DEPTH = 8 → 8 accepted, 9th stalls. Raise ready → all 9 delivered in order with their original ticks.
- Store to 0x40000000 and load from 0x80000010 → no stall, no entry.
- Three stores, then a halt store to 0x80000004, then another store:
  - the extra store stalls
  - entries are delivered in order with the halt last
  - FSM reaches HALTED and the extra store stalls forever
- Assert rst_ni low for 1 cycle with 4 entries queued → FIFO empty, dbg_en_o = 0, tick restarts at 0, FSM in RUN.
